// File: rtl/serial_adder_ctrl_pkg.sv
// Shared state encoding and default width for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell from the iterative-networks lab.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell reused over N cycles, LSB first,
// with the carry held in a flop between bits.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  sum_sh_q, sum_sh_d;
    logic          c_ff_q, c_ff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  s_q, s_d;
    logic          cout_q, cout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic fa_s, fa_cout;

    fulladder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (c_ff_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        c_ff_d   = c_ff_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    c_ff_d  = Cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = {fa_s, sum_sh_q[N-1:1]};
                c_ff_d   = fa_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // After N shifts the first sum bit has landed in bit 0.
                    s_d     = sum_sh_d;
                    cout_d  = fa_cout;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            c_ff_q   <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            c_ff_q   <= c_ff_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: N=8 vectors plus an exhaustive N=5 sweep.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, s8;
    logic       start5, cin5, busy5, done5, cout5;
    logic [4:0] a5, b5, s5;

    serial_adder_ctrl #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
    );

    serial_adder_ctrl #(.N(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5), .A(a5), .B(b5), .Cin(cin5),
        .busy(busy5), .done(done5), .S(s5), .Cout(cout5)
    );

    int n_chk = 0;
    int n_fail = 0;
    int dn5 = 0;

    always @(negedge clk) if (done5 === 1'b1) dn5++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // k counts negedges after the accepting edge; inj_k/rst_k < 0 disables those events.
    task automatic add8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [8:0] exp, input logic [8:0] prev,
                        input int inj_k, input int rst_k);
        int   nb, nd, dk, hold_lim;
        logic hold_ok;
        nb = 0; nd = 0; dk = -1; hold_ok = 1'b1;
        hold_lim = (rst_k >= 0) ? rst_k + 1 : 8;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 0) start8 = 1'b0;
            if (busy8) nb++;
            if (done8) begin nd++; dk = k; end
            if (k < hold_lim && {cout8, s8} !== prev) hold_ok = 1'b0;
            if (k == rst_k + 1 && rst_k >= 0) begin
                chk({tag, "_rst_busy"}, busy8, 0);
                chk({tag, "_rst_done"}, done8, 0);
                chk({tag, "_rst_sum"}, {cout8, s8}, 0);
                rst = 1'b0;
            end
            if (k == inj_k) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
            if (k == inj_k + 1 && inj_k >= 0) begin start8 = 1'b0; a8 = 8'h77; b8 = 8'h99; end
            if (k == rst_k) rst = 1'b1;
        end
        chk({tag, "_hold"}, hold_ok, 1);
        if (rst_k >= 0) begin
            chk({tag, "_nodone"}, nd, 0);
        end else begin
            chk({tag, "_sum"}, {cout8, s8}, exp);
            chk({tag, "_busy_cyc"}, nb, 8);
            chk({tag, "_done_cnt"}, nd, 1);
            chk({tag, "_done_at"}, dk, 8);
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", {cout8, s8}, 0);
        chk("rst_busy5", busy5, 0);
        rst = 1'b0;

        add8("zero",   8'h00, 8'h00, 1'b0, 9'h000, 9'h000, -1, -1);
        add8("ripple", 8'hFF, 8'h01, 1'b0, 9'h100, 9'h000, -1, -1);
        add8("mix",    8'h5A, 8'h3C, 1'b1, 9'h097, 9'h100, -1, -1);
        add8("allone", 8'hFF, 8'hFF, 1'b1, 9'h1FF, 9'h097, -1, -1);
        add8("ignst",  8'h12, 8'h34, 1'b0, 9'h046, 9'h1FF,  3, -1);
        add8("abort",  8'hAA, 8'h55, 1'b0, 9'h000, 9'h046, -1,  4);
        add8("post",   8'h0F, 8'h01, 1'b0, 9'h010, 9'h000, -1, -1);

        // N=5 exhaustive sweep, each start N+2 edges after the previous one.
        @(negedge clk);
        a5 = 5'd0; b5 = 5'd0; cin5 = 1'b0; start5 = 1'b1;
        for (int v = 0; v < 2048; v++) begin
            int e;
            e = int'(v[4:0]) + int'(v[9:5]) + int'(v[10]);
            for (int k = 0; k <= 6; k++) begin
                @(negedge clk);
                if (k == 0) begin start5 = 1'b0; a5 = ~a5; b5 = ~b5; cin5 = ~cin5; end
                if (k == 5) chk("sweep", {done5, cout5, s5}, 64 + e);
                if (k == 6 && v < 2047) begin
                    a5 = 5'((v + 1) & 31);
                    b5 = 5'(((v + 1) >> 5) & 31);
                    cin5 = 1'(((v + 1) >> 10) & 1);
                    start5 = 1'b1;
                end
            end
        end
        repeat (4) @(negedge clk);
        chk("sweep_ndone", dn5, 2048);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
